// File: rtl/fwd_pipe_pkg.sv
// fwd_pipe_pkg: shared types and helpers for the writeback-tracking pipe.
//
// Contents:
//   lc3b_word / lc3b_reg  : default-width LC-3b data word and register index
//   lc3b_fwd_entry        : one pipe entry at default widths
//                           {valid, we, dest, data, ready}
//   fwd_entry_bits()      : packed width of an entry for arbitrary widths, used
//                           by the parametrised modules to size their buses
package fwd_pipe_pkg;

  localparam int LC3B_WORD_W = 16;
  localparam int LC3B_REG_W  = 3;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_REG_W-1:0]  lc3b_reg;

  // Field order (MSB to LSB) is shared by every parametrised equivalent, so a
  // flat bus can be cast to and from the struct without reshuffling.
  typedef struct packed {
    logic     valid;
    logic     we;
    lc3b_reg  dest;
    lc3b_word data;
    logic     ready;
  } lc3b_fwd_entry;

  // valid + we + ready are three single bits around dest and data.
  function automatic int fwd_entry_bits(int data_width, int reg_bits);
    return data_width + reg_bits + 3;
  endfunction

endpackage

// File: rtl/fwd_stage.sv
// fwd_stage: a single pipe entry register.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the whole entry)
//   load       : take the entry presented on d (pipeline shift)
//   kill       : force valid low after this edge (wins over load and upd)
//   upd        : late data for this entry; only honoured while holding and
//                only if the entry is valid
//   upd_data   : late data value
//   d          : incoming entry {valid, we, dest, data, ready}
//   q          : registered entry, same layout
//
// When load and upd are both high the late data belongs to the entry that is
// leaving; the parent routes it into the next stage's d instead.
module fwd_stage
  import fwd_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int REG_BITS   = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic                             kill,
  input  logic                             upd,
  input  logic [DATA_WIDTH-1:0]            upd_data,
  input  logic [DATA_WIDTH+REG_BITS+2:0]   d,
  output logic [DATA_WIDTH+REG_BITS+2:0]   q
);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_BITS-1:0]   dest;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;
  } entry_t;

  entry_t cur;
  entry_t nxt;

  assign cur = entry_t'(q);

  always_comb begin
    nxt = cur;
    if (load) begin
      nxt = entry_t'(d);
    end else if (upd && cur.valid) begin
      nxt.data  = upd_data;
      nxt.ready = 1'b1;
    end
    if (kill) begin
      nxt.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/fwd_pipe.sv
// fwd_pipe: parametrised writeback-tracking pipe with multi-source forwarding.
//
// A bank of DEPTH entries runs from the exec output (stage 0, youngest) to
// writeback (stage DEPTH-1). Each entry carries valid, we, dest, data, ready.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   advance          : shift the bank by one stage on the edge, else hold
//   flush            : kill the youngest KILL_STAGES entries and the incoming one
//   in_valid/in_we/in_dest/in_data/in_ready : entry entering stage 0
//   upd_en, upd_data : late (load) data for the entry sitting in UPD_STAGE
//   src_reg          : NUM_SRC lookup registers, port i at [i*REG_BITS +: REG_BITS]
//   fwd_hit/fwd_data : per-port forwarding result (youngest match wins)
//   fwd_stall        : some port matched an entry whose data is not final
//   wb_valid/wb_we/wb_dest/wb_data : combinational view of stage DEPTH-1
module fwd_pipe
  import fwd_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int REG_BITS    = 3,
  parameter int DEPTH       = 3,
  parameter int NUM_SRC     = 2,
  parameter int UPD_STAGE   = 1,
  parameter int KILL_STAGES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          advance,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic                          in_we,
  input  logic [REG_BITS-1:0]           in_dest,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_ready,
  input  logic                          upd_en,
  input  logic [DATA_WIDTH-1:0]         upd_data,
  input  logic [NUM_SRC*REG_BITS-1:0]   src_reg,
  output logic [NUM_SRC-1:0]            fwd_hit,
  output logic [NUM_SRC*DATA_WIDTH-1:0] fwd_data,
  output logic                          fwd_stall,
  output logic                          wb_valid,
  output logic                          wb_we,
  output logic [REG_BITS-1:0]           wb_dest,
  output logic [DATA_WIDTH-1:0]         wb_data
);

  localparam int ENTRY_W = fwd_entry_bits(DATA_WIDTH, REG_BITS);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_BITS-1:0]   dest;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;
  } entry_t;

  // Late data arriving on the same edge as a shift must travel with the entry
  // into the next stage, so the shifted-in value is the updated view.
  function automatic entry_t apply_late(entry_t e, logic en, logic [DATA_WIDTH-1:0] val);
    entry_t r;
    r = e;
    if (en && e.valid) begin
      r.data  = val;
      r.ready = 1'b1;
    end
    return r;
  endfunction

  logic [ENTRY_W-1:0] d_bus [DEPTH];
  logic [ENTRY_W-1:0] q_bus [DEPTH];
  entry_t             st    [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam bit KILL_HERE = (k < KILL_STAGES);
    localparam bit UPD_HERE  = (k == UPD_STAGE);

    if (k == 0) begin : g_head
      // The incoming entry is dropped by flush even when KILL_STAGES is 0.
      assign d_bus[k] = {in_valid & ~flush, in_we, in_dest, in_data, in_ready};
    end else begin : g_body
      localparam bit UPD_PREV = ((k - 1) == UPD_STAGE);
      assign d_bus[k] = apply_late(st[k-1], upd_en & UPD_PREV, upd_data);
    end

    fwd_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_BITS   (REG_BITS)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (advance),
      .kill     (flush & KILL_HERE),
      .upd      (upd_en & UPD_HERE),
      .upd_data (upd_data),
      .d        (d_bus[k]),
      .q        (q_bus[k])
    );

    assign st[k] = entry_t'(q_bus[k]);
  end

  assign wb_valid = st[DEPTH-1].valid;
  assign wb_we    = st[DEPTH-1].valid & st[DEPTH-1].we;
  assign wb_dest  = st[DEPTH-1].dest;
  assign wb_data  = st[DEPTH-1].data;

  // Per-port priority search, youngest first. Only the first match counts:
  // an older ready copy of the same register is stale once a younger
  // producer exists, so a not-ready winner must stall rather than fall back.
  // Lookups see registered state only; late data shows up one cycle later.
  always_comb begin
    logic                found;
    logic                winner_ready;
    logic [REG_BITS-1:0] key;
    found        = 1'b0;
    winner_ready = 1'b0;
    key          = '0;
    fwd_hit      = '0;
    fwd_data     = '0;
    fwd_stall    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      found        = 1'b0;
      winner_ready = 1'b0;
      key          = src_reg[i*REG_BITS +: REG_BITS];
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && st[k].valid && st[k].we && (st[k].dest == key)) begin
          found                                = 1'b1;
          winner_ready                         = st[k].ready;
          fwd_hit[i]                           = 1'b1;
          fwd_data[i*DATA_WIDTH +: DATA_WIDTH] = st[k].data;
        end
      end
      if (found && !winner_ready) begin
        fwd_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_pipe.sv
// tb_fwd_pipe: directed scenarios plus randomized traffic for fwd_pipe,
// checked every cycle against a behavioural model of the entry bank.
module tb_fwd_pipe;

  localparam int DW = 16;
  localparam int RB = 3;
  localparam int D  = 3;
  localparam int NS = 2;
  localparam int US = 1;
  localparam int KS = 1;

  logic              clk;
  logic              rst_n;
  logic              advance;
  logic              flush;
  logic              in_valid;
  logic              in_we;
  logic [RB-1:0]     in_dest;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              upd_en;
  logic [DW-1:0]     upd_data;
  logic [NS*RB-1:0]  src_reg;
  logic [NS-1:0]     fwd_hit;
  logic [NS*DW-1:0]  fwd_data;
  logic              fwd_stall;
  logic              wb_valid;
  logic              wb_we;
  logic [RB-1:0]     wb_dest;
  logic [DW-1:0]     wb_data;

  fwd_pipe #(
    .DATA_WIDTH (DW), .REG_BITS (RB), .DEPTH (D),
    .NUM_SRC (NS), .UPD_STAGE (US), .KILL_STAGES (KS)
  ) dut (
    .clk (clk), .rst_n (rst_n), .advance (advance), .flush (flush),
    .in_valid (in_valid), .in_we (in_we), .in_dest (in_dest),
    .in_data (in_data), .in_ready (in_ready),
    .upd_en (upd_en), .upd_data (upd_data), .src_reg (src_reg),
    .fwd_hit (fwd_hit), .fwd_data (fwd_data), .fwd_stall (fwd_stall),
    .wb_valid (wb_valid), .wb_we (wb_we), .wb_dest (wb_dest), .wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v;
    bit we;
    int dest;
    int data;
    bit rdy;
  } ent_t;

  ent_t m [D];
  ent_t t [D];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) m[k] = '{0, 0, 0, 0, 0};
    end else begin
      t = m;
      if (upd_en && t[US].v) begin
        t[US].data = int'(upd_data);
        t[US].rdy  = 1'b1;
      end
      if (advance) begin
        for (int k = D - 1; k > 0; k--) t[k] = t[k-1];
        t[0] = '{in_valid && !flush, in_we, int'(in_dest), int'(in_data), in_ready};
      end
      if (flush) begin
        for (int k = 0; k < KS; k++) t[k].v = 1'b0;
      end
      m = t;
    end
  end

  logic [NS-1:0]    e_hit;
  logic [NS*DW-1:0] e_data;
  logic             e_stall;

  always @(negedge clk) begin
    e_hit   = '0;
    e_data  = '0;
    e_stall = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int key;
      bit found;
      key   = int'(src_reg[i*RB +: RB]);
      found = 1'b0;
      for (int k = 0; k < D; k++) begin
        if (!found && m[k].v && m[k].we && m[k].dest == key) begin
          found             = 1'b1;
          e_hit[i]          = 1'b1;
          e_data[i*DW +: DW] = m[k].data[DW-1:0];
          if (!m[k].rdy) e_stall = 1'b1;
        end
      end
    end
    chk("cyc_wb_valid", wb_valid, m[D-1].v);
    chk("cyc_wb_we", wb_we, m[D-1].v & m[D-1].we);
    chk("cyc_wb_dest", wb_dest, m[D-1].dest);
    chk("cyc_wb_data", wb_data, m[D-1].data);
    chk("cyc_fwd_hit", fwd_hit, e_hit);
    chk("cyc_fwd_data", fwd_data, e_data);
    chk("cyc_fwd_stall", fwd_stall, e_stall);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    advance = 0; flush = 0; in_valid = 0; in_we = 0; in_dest = '0;
    in_data = '0; in_ready = 0; upd_en = 0; upd_data = '0;
  endtask

  task automatic push(input logic v, input logic we, input logic [RB-1:0] dest,
                      input logic [DW-1:0] data, input logic rdy);
    in_valid = v; in_we = we; in_dest = dest; in_data = data; in_ready = rdy;
    advance = 1;
    tick();
    in_valid = 0; advance = 0;
  endtask

  task automatic drain();
    in_valid = 0; advance = 1;
    repeat (D) tick();
    advance = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    src_reg = '0;

    // Reset state
    tick(); tick();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_stall", fwd_stall, 0);
    rst_n = 1;
    tick();

    // Shift and writeback
    push(1, 1, 3'd3, 16'h1234, 1);
    advance = 1;
    tick(); tick();
    #1;
    chk("wb_we_after3", wb_we, 1);
    chk("wb_dest_after3", wb_dest, 3);
    chk("wb_data_after3", wb_data, 16'h1234);
    chk("model_wb_data", m[D-1].data, 16'h1234);
    tick();
    #1;
    chk("wb_valid_after4", wb_valid, 0);
    advance = 0;

    // Youngest-priority forward
    push(1, 1, 3'd5, 16'h0001, 1);
    push(0, 0, 3'd0, 16'h0000, 0);
    push(1, 1, 3'd5, 16'h0002, 1);
    src_reg = {3'd4, 3'd5};
    #1;
    chk("young_hit", fwd_hit, 2'b01);
    chk("young_data0", fwd_data[DW-1:0], 16'h0002);
    chk("young_data1", fwd_data[2*DW-1:DW], 16'h0000);
    chk("young_wb", wb_data, 16'h0001);

    // Load stall and late fill
    drain();
    push(1, 1, 3'd2, 16'h1111, 0);
    src_reg = {3'd4, 3'd2};
    #1;
    chk("load_stall", fwd_stall, 1);
    chk("load_hit_data", fwd_data[DW-1:0], 16'h1111);
    advance = 1;
    tick();
    advance = 0; upd_en = 1; upd_data = 16'hBEEF;
    #1;
    chk("no_bypass_stall", fwd_stall, 1);
    chk("model_notready", m[US].rdy, 0);
    tick();
    upd_en = 0;
    #1;
    chk("fill_stall", fwd_stall, 0);
    chk("fill_data", fwd_data[DW-1:0], 16'hBEEF);

    // Stall hold
    push(1, 1, 3'd7, 16'h0077, 1);
    src_reg = {3'd7, 3'd2};
    repeat (5) tick();
    #1;
    chk("hold_wb_we", wb_we, 1);
    chk("hold_wb_dest", wb_dest, 2);
    chk("hold_wb_data", wb_data, 16'hBEEF);
    chk("hold_hit", fwd_hit, 2'b11);
    chk("hold_data", fwd_data, 32'h0077BEEF);
    chk("hold_stall", fwd_stall, 0);

    // Flush with advance
    drain();
    push(1, 1, 3'd1, 16'h0011, 1);
    in_valid = 1; in_we = 1; in_dest = 3'd6; in_data = 16'h0066; in_ready = 1;
    flush = 1; advance = 1;
    tick();
    idle();
    src_reg = {3'd1, 3'd6};
    #1;
    chk("flush_hit", fwd_hit, 2'b10);
    chk("flush_data", fwd_data, 32'h00110000);

    // Reset mid-operation
    drain();
    push(1, 1, 3'd1, 16'h0101, 1);
    push(1, 1, 3'd2, 16'h0202, 1);
    push(1, 1, 3'd3, 16'h0303, 0);
    src_reg = {3'd3, 3'd1};
    #1;
    chk("pre_rst_hit", fwd_hit, 2'b11);
    rst_n = 0;
    #1;
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_hit", fwd_hit, 0);
    chk("midrst_stall", fwd_stall, 0);
    rst_n = 1;
    tick();
    #1;
    chk("post_rst_wb_valid", wb_valid, 0);
    chk("post_rst_hit", fwd_hit, 0);

    // Randomized traffic, checked by the per-cycle compare
    for (int n = 0; n < 1500; n++) begin
      advance  = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 7) == 0);
      in_valid = $urandom_range(0, 1);
      in_we    = ($urandom_range(0, 3) != 0);
      in_dest  = RB'($urandom_range(0, 7));
      in_data  = DW'($urandom);
      in_ready = ($urandom_range(0, 2) != 0);
      upd_en   = ($urandom_range(0, 2) == 0);
      upd_data = DW'($urandom);
      src_reg  = (NS*RB)'($urandom);
      if (n % 250 == 249) begin
        rst_n = 0;
        #2;
        rst_n = 1;
      end
      tick();
    end

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_pipe.md
Name: fwd_pipe

Overview:
Parametrised writeback-tracking pipe for the next-generation pipelined LC-3b core. It replaces the fixed hand-chained dest/data transition registers (three dest stages, two data stages) with a DEPTH-stage bank of entries. Each entry carries valid, write-enable, destination register, data and data-ready. It adds three things the current chains lack: bubble/flush, late data fill (loads), and multi-source forwarding with stall detect for the decode/exec boundary.

Parameters:
DATA_WIDTH, 16, width of result data.
REG_BITS, 3, register-index width.
DEPTH, 3, number of stages from exec output to writeback (stage 0 youngest, stage DEPTH-1 = writeback).
NUM_SRC, 2, number of forwarding lookup ports.
UPD_STAGE, 1, stage index receiving late data (memory stage); 0 <= UPD_STAGE < DEPTH.
KILL_STAGES, 1, number of youngest stages cleared by flush; 0..DEPTH.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
advance  in  1  pipeline load (global_load equivalent); shift when 1, hold when 0
flush  in  1  kill youngest KILL_STAGES entries and the incoming entry
in_valid  in  1  entry presented at stage 0 input
in_we  in  1  entry writes regfile
in_dest  in  REG_BITS  destination register
in_data  in  DATA_WIDTH  result (ALU/PC-relative)
in_ready  in  1  in_data is final (0 for loads)
upd_en  in  1  late data for entry in UPD_STAGE
upd_data  in  DATA_WIDTH  late data (MDR value)
src_reg  in  NUM_SRC*REG_BITS  lookup registers, port i at [i*REG_BITS +: REG_BITS]
fwd_hit  out  NUM_SRC  match found for port i
fwd_data  out  NUM_SRC*DATA_WIDTH  forwarded value for port i
fwd_stall  out  1  OR over ports of (hit and matched entry not ready)
wb_valid  out  1  stage DEPTH-1 valid
wb_we  out  1  valid & we of stage DEPTH-1
wb_dest  out  REG_BITS  stage DEPTH-1 dest
wb_data  out  DATA_WIDTH  stage DEPTH-1 data

Behaviour:
- Reset (async, rst_n=0): all stages valid=0, we=0, dest=0, data=0, ready=0. All outputs therefore 0. Release is synchronous to the next clk edge.
- advance=1, rising edge: stage k <= stage k-1 for k>=1; stage 0 <= {in_valid & ~flush, in_we, in_dest, in_data, in_ready}; stage DEPTH-1 contents are dropped (already written back).
- advance=0: contents hold, except upd_en and flush, which still apply.
- upd_en: if stage UPD_STAGE is valid, set its data=upd_data and ready=1. Under advance=1, the updated values move into stage UPD_STAGE+1 on the same edge; if UPD_STAGE=DEPTH-1 they are dropped. upd_en on an invalid entry is ignored.
- flush: after the edge, stages 0..KILL_STAGES-1 have valid=0 (with advance=1 this covers the shifted-in positions). Older stages are unaffected. Flush beats upd_en on the same entry.
- wb_* are combinational from stage DEPTH-1 registers (zero latency). The regfile writes on the edge.
- Forwarding is combinational, per port. Search stages 0..DEPTH-1 in that order; the first with valid & we & dest==src_reg[i] wins (youngest priority).
  - Hit: fwd_hit[i]=1, fwd_data[i]=data. If the winner is not ready, set fwd_stall=1; older ready matches must not be used.
  - No match: fwd_hit[i]=0, fwd_data[i]=0.
- The current-cycle upd_data is not bypassed into the lookup; the stall resolves one cycle after upd_en.
- No arithmetic; all widths pass through unchanged.

Decomposition:
- lc3b_types gains a packed struct lc3b_fwd_entry {valid, we, lc3b_reg dest, lc3b_word data, ready} for default widths. The module uses a parametrised local equivalent.
- One sub-module, fwd_stage: a single entry register with async reset, load/shift, kill and late-update inputs. It is instantiated DEPTH times in a generate loop. The lookup priority encoder stays in fwd_pipe.

Test Plan:
1. Reset mid-operation: fill 3 valid entries, then pulse rst_n=0 between edges -> wb_valid, fwd_hit, fwd_stall are 0 immediately; all stage valids are 0 after release.
2. Shift and writeback: push {we=1, dest=R3, data=0x1234, ready=1} with advance=1 for 3 edges -> wb_we=1, wb_dest=3, wb_data=0x1234 after the 3rd edge; gone after the 4th.
3. Youngest-priority forward: stage 2 holds R5=0x0001, stage 0 holds R5=0x0002, src_reg port0=R5 -> fwd_hit[0]=1, fwd_data=0x0002; port1=R4 -> fwd_hit[1]=0, fwd_data=0.
4. Load stall and fill: push R2 with ready=0; port0=R2 -> fwd_stall=1. After an advance, the entry is in stage 1. Apply upd_en with upd_data=0xBEEF and advance=0 -> fwd_stall=0 and fwd_data=0xBEEF on the next cycle.
5. Stall hold: advance=0 for 5 cycles with entries present -> all wb_* and fwd_* are unchanged.
6. Flush with advance: stage 0 holds R1, in_valid=1 for R6, flush=1, advance=1 -> stage 0 invalid (R6 dropped); R1 moves to stage 1 and is unaffected (KILL_STAGES=1); lookup R6 -> no hit.
